bram_multi_rd_port: RTL and testbench

BRAM_MULTI_RD_PORT -- requirements
Module: bram_multi_rd_port

---
 rtl/bram_pkg.sv | 16 +
 rtl/bram_clr_seq.sv | 54 +++++
 rtl/bram_multi_rd_port.sv | 110 +++++++++++
 tb/tb_bram_multi_rd_port.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared types and constants for the multi-read-port BRAM.
// BRAM_OUTREG_EN selects the extra registered output stage (read latency 2).
package bram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

`ifdef BRAM_OUTREG_EN
    localparam int unsigned RD_LATENCY = 2;
`else
    localparam int unsigned RD_LATENCY = 1;
`endif

endpackage

// File: rtl/bram_clr_seq.sv
// Clear sequencer: sweeps every address once after reset or a clr request.
module bram_clr_seq
    import bram_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    output logic                    busy,
    output logic [C_ADDR_WIDTH-1:0] clr_addr
);

    clr_state_e              state_q, state_d;
    logic [C_ADDR_WIDTH-1:0] cnt_q, cnt_d;

    // Reset lands in CLEAR so the memory is always swept before first use
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + C_ADDR_WIDTH'(1);
                if (&cnt_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy     = (state_q == ST_CLEAR);
    assign clr_addr = cnt_q;

endmodule

// File: rtl/bram_multi_rd_port.sv
// Single-write, multi-read BRAM with write-first collision and self-clear.
// Define BRAM_OUTREG_EN to add a registered output stage (read latency 2).
module bram_multi_rd_port
    import bram_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH = 8,
    parameter int unsigned C_DATA_WIDTH = 8,
    parameter int unsigned C_RD_PORTS   = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wen,
    input  logic [C_ADDR_WIDTH-1:0]            waddr,
    input  logic [C_DATA_WIDTH-1:0]            wdata,
    input  logic                               ren,
    input  logic [C_RD_PORTS*C_ADDR_WIDTH-1:0] raddr,
    output logic [C_RD_PORTS*C_DATA_WIDTH-1:0] rdata,
    output logic                               rvalid,
    input  logic                               clr,
    output logic                               busy
);

    localparam int unsigned DEPTH = 2 ** C_ADDR_WIDTH;

    logic [C_DATA_WIDTH-1:0] mem [DEPTH];
    logic [C_ADDR_WIDTH-1:0] clr_addr;
    logic                    rvalid_q;

    bram_clr_seq #(
        .C_ADDR_WIDTH (C_ADDR_WIDTH)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .busy     (busy),
        .clr_addr (clr_addr)
    );

    // Storage has no reset; the sequencer zeroes it after every reset
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_addr] <= '0;
        end else if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= ren;
        end
    end

    for (genvar k = 0; k < C_RD_PORTS; k++) begin : g_rd
        logic [C_ADDR_WIDTH-1:0] addr_c;
        logic [C_DATA_WIDTH-1:0] rd_q;

        assign addr_c = raddr[k*C_ADDR_WIDTH +: C_ADDR_WIDTH];

        // Reads during a clear return zero; same-cycle writes bypass the array
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_q <= '0;
            end else if (ren) begin
                if (busy) begin
                    rd_q <= '0;
                end else if (wen && (addr_c == waddr)) begin
                    rd_q <= wdata;
                end else begin
                    rd_q <= mem[addr_c];
                end
            end
        end

`ifdef BRAM_OUTREG_EN
        logic [C_DATA_WIDTH-1:0] out_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_q <= '0;
            end else begin
                out_q <= rd_q;
            end
        end

        assign rdata[k*C_DATA_WIDTH +: C_DATA_WIDTH] = out_q;
`else
        assign rdata[k*C_DATA_WIDTH +: C_DATA_WIDTH] = rd_q;
`endif
    end

`ifdef BRAM_OUTREG_EN
    logic rvalid_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_out_q <= 1'b0;
        end else begin
            rvalid_out_q <= rvalid_q;
        end
    end

    assign rvalid = rvalid_out_q;
`else
    assign rvalid = rvalid_q;
`endif

endmodule

// File: tb/tb_bram_multi_rd_port.sv
// Directed + random bench for bram_multi_rd_port with a queue-based scoreboard.
module tb_bram_multi_rd_port;
    import bram_pkg::*;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned NP    = 8;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned L     = RD_LATENCY;

    typedef struct packed {
        logic             v;
        logic [NP*DW-1:0] d;
    } exp_t;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             wen   = 1'b0;
    logic [AW-1:0]    waddr = '0;
    logic [DW-1:0]    wdata = '0;
    logic             ren   = 1'b0;
    logic [NP*AW-1:0] raddr = '0;
    logic             clr   = 1'b0;
    logic [NP*DW-1:0] rdata;
    logic             rvalid;
    logic             busy;

    exp_t             sb [$];
    logic [DW-1:0]    mdl_mem [DEPTH];
    logic             mdl_busy;
    int unsigned      mdl_cnt;
    logic [NP*DW-1:0] last_d;
    int               n_pass  = 0;
    int               n_fail  = 0;
    int               n_total = 0;

    always #5 clk = ~clk;

    bram_multi_rd_port #(
        .C_ADDR_WIDTH (AW),
        .C_DATA_WIDTH (DW),
        .C_RD_PORTS   (NP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wen    (wen),
        .waddr  (waddr),
        .wdata  (wdata),
        .ren    (ren),
        .raddr  (raddr),
        .rdata  (rdata),
        .rvalid (rvalid),
        .clr    (clr),
        .busy   (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        mdl_busy = 1'b1;
        mdl_cnt  = 0;
        last_d   = '0;
        sb.delete();
        for (int i = 1; i < int'(L); i++) sb.push_back('{v: 1'b0, d: '0});
    endtask

    // Predict this cycle's read, advance the model, clock once and compare
    task automatic step(input string tag);
        exp_t          e;
        logic [AW-1:0] a;
        e.v = ren;
        e.d = last_d;
        if (ren) begin
            for (int k = 0; k < int'(NP); k++) begin
                a = raddr[k*AW +: AW];
                if (mdl_busy)                e.d[k*DW +: DW] = '0;
                else if (wen && a == waddr)  e.d[k*DW +: DW] = wdata;
                else                         e.d[k*DW +: DW] = mdl_mem[a];
            end
        end
        last_d = e.d;
        sb.push_back(e);
        if (mdl_busy) begin
            mdl_mem[AW'(mdl_cnt)] = '0;
            if (mdl_cnt == DEPTH - 1) begin
                mdl_busy = 1'b0;
                mdl_cnt  = 0;
            end else begin
                mdl_cnt++;
            end
        end else begin
            if (wen) mdl_mem[waddr] = wdata;
            if (clr) begin
                mdl_busy = 1'b1;
                mdl_cnt  = 0;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".busy"}, 64'(busy), 64'(mdl_busy));
        if (sb.size() >= L) begin
            e = sb.pop_front();
            chk({tag, ".rvalid"}, 64'(rvalid), 64'(e.v));
            chk({tag, ".rdata"}, 64'(rdata), 64'(e.d));
        end
    endtask

    task automatic rand_traffic(input int unsigned amax);
        ren   = 1'($urandom_range(0, 1));
        wen   = 1'($urandom_range(0, 1));
        waddr = AW'($urandom_range(0, amax));
        wdata = DW'($urandom);
        for (int k = 0; k < int'(NP); k++) raddr[k*AW +: AW] = AW'($urandom_range(0, amax));
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mdl_mem[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.rdata", 64'(rdata), 64'd0);
        chk("rst.rvalid", 64'(rvalid), 64'd0);
        chk("rst.busy", 64'(busy), 64'd1);
        rst = 1'b0;
        model_reset();

        // Automatic clear after reset; writes and a stray clr are ignored
        for (int i = 0; i < int'(DEPTH); i++) begin
            rand_traffic(255);
            wen = 1'b1;
            clr = (i == 100);
            step("autoclr");
        end
        clr = 1'b0;

        // Every address reads zero after the sweep
        wen = 1'b0;
        ren = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            for (int k = 0; k < int'(NP); k++) raddr[k*AW +: AW] = AW'(i + k);
            step("zero_rd");
        end

        // Write 5, then alternate ports between 5 and 6
        ren = 1'b0; wen = 1'b1; waddr = AW'(5); wdata = 8'hA5;
        step("wr5");
        wen = 1'b0; ren = 1'b1;
        for (int k = 0; k < int'(NP); k++) raddr[k*AW +: AW] = (k % 2 == 0) ? AW'(5) : AW'(6);
        step("rd56");
        ren = 1'b0;
        step("hold0");
        step("hold1");

        // All ports on the same address
        ren = 1'b1;
        for (int k = 0; k < int'(NP); k++) raddr[k*AW +: AW] = AW'(5);
        step("same_addr");

        // Write-first collision on port 2 only
        wen = 1'b1; waddr = AW'(9); wdata = 8'h3C;
        raddr[2*AW +: AW] = AW'(9);
        step("collide");
        wen = 1'b0; ren = 1'b1;
        step("post_collide");
        ren = 1'b0;
        step("drain0");

        // Dense random traffic over a small window to provoke collisions
        for (int i = 0; i < 300; i++) begin
            rand_traffic(15);
            step("rand");
        end

        // clr mid-traffic, with a second clr during the sweep
        rand_traffic(15);
        clr = 1'b1;
        step("clr_req");
        for (int i = 0; i < 300; i++) begin
            rand_traffic(15);
            clr = (i == 50);
            step("clr_traffic");
        end
        clr = 1'b0; wen = 1'b0; ren = 1'b1;
        for (int k = 0; k < int'(NP); k++) raddr[k*AW +: AW] = AW'(5);
        step("rd5_cleared");
        ren = 1'b0;
        for (int i = 0; i < int'(L); i++) step("drain1");

        // Reset at clear counter 100 restarts the sweep
        clr = 1'b1;
        step("clr_req2");
        clr = 1'b0;
        for (int i = 0; i < 300 && mdl_cnt != 100; i++) step("to_cnt100");
        chk("cnt100_reached", 64'(mdl_cnt), 64'd100);
        rst = 1'b1;
        #1;
        chk("midrst.rdata", 64'(rdata), 64'd0);
        chk("midrst.rvalid", 64'(rvalid), 64'd0);
        chk("midrst.busy", 64'(busy), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("midrst.busy_hold", 64'(busy), 64'd1);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < int'(DEPTH) + 4; i++) begin
            rand_traffic(255);
            step("reclear");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
